fsk_div_scheduler: RTL
======================

// Module: fsk_div_scheduler
// PURPOSE
//  Sequences the loadable frequency divider (freqdivider) for FSK-style modulation.
//  Accepts symbols over a valid/ready handshake and maps each to a divide count via a
//  programmable tone table. Holds each tone for CARRIES_PER_SYM divider carry pulses.
//  Sits between the symbol source and the divider; it owns the divider's cnt, init and sel.
// PARAMETERS
//  CNT_W            3   divider count width; must match freqdivider cnt
//  SYM_W            2   symbol width; tone table depth = 2**SYM_W
//  CARRIES_PER_SYM  16  divider carry pulses per symbol (>=2)
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       asynchronous, active-low reset
//  enable     in   1       1 = accept symbols; 0 = finish current symbol, then idle
//  cfg_we     in   1       tone table write strobe
//  cfg_addr   in   SYM_W   tone table index
//  cfg_data   in   CNT_W   divide count for that index
//  sym_valid  in   1       symbol offered
//  sym_data   in   SYM_W   symbol value
//  sym_ready  out  1       symbol accepted when sym_valid & sym_ready
//  div_carry  in   1       freqdivider carry_out
//  div_cnt    out  CNT_W   count presented to freqdivider cnt
//  div_init   out  1       one-cycle load pulse to freqdivider init
//  div_sel    out  1       freqdivider sel; driven 0 (auto-reload mode) in this revision
//  busy       out  1       1 in LOAD or RUN
//  sym_done   out  1       one-cycle pulse on a symbol's final carry
//  underrun   out  1       one-cycle pulse: symbol ended, enable=1, no next symbol pending
// BEHAVIOUR
//  Reset: state IDLE; tone table, div_cnt, carry counter, pending register all 0;
//   every output 0 except sym_ready, which follows the state rules below.
//  FSM IDLE -> LOAD -> RUN -> (LOAD | IDLE):
//   IDLE: sym_ready = enable. On accept, capture sym_data -> LOAD next cycle.
//   LOAD (1 cycle): div_cnt <= tone[sym]; div_init = 1; carry counter <= 0 -> RUN.
//   RUN: counts div_carry pulses. sym_ready = enable & !pending & (count == CARRIES_PER_SYM-1).
//    An accepted symbol goes into the pending register.
//    On div_carry with count == CARRIES_PER_SYM-1: sym_done = 1; if pending -> LOAD
//    with the pending symbol and clear pending; else -> IDLE, with underrun = enable.
//  Latency: accept at cycle t -> div_init at t+1 -> RUN at t+2. Back-to-back symbols
//   have exactly one LOAD cycle between them.
//  div_carry is ignored outside RUN. Carry counter width = clog2(CARRIES_PER_SYM);
//   it never wraps, because the terminal carry always leaves RUN.
//  div_cnt holds its last value in IDLE. div_sel is constant 0.
//  A cfg write takes effect on the next LOAD. A write to the entry in use does not
//   change the latched div_cnt. A cfg write and a LOAD in the same cycle: LOAD reads
//   the old value.
//  enable falling in RUN: the current symbol completes, no new accept, no underrun.
//  rst asserted mid-symbol: immediate return to reset state; the pending symbol is lost.
// CONFIGURATION
//  FSK_IDLE_TONE_EN defined: on underrun the FSM goes to LOAD with symbol 0 (idle tone)
//   instead of IDLE, so the carrier never stops while enable = 1. underrun still pulses.
//   The idle symbol completes in full before the next real symbol loads.
//  Not defined: the carrier stops in IDLE as described above.
// STRUCTURE
//  modulation_pkg: FSM state encoding (IDLE/LOAD/RUN), default widths, CARRIES_PER_SYM.
//  Sub-module fsk_carry_counter: counts div_carry pulses, flags the terminal count,
//   clears on LOAD.
//  Tone table and FSM stay in this module.
// TESTING (bench instantiates freqdivider driven by this block)
//  1 Reset: hold rst=0 -> all outputs 0, div_init never pulses; release -> sym_ready=1
//    when enable=1.
//  2 tone={7,5,3,1}, send symbol 2 -> div_init at t+1 with div_cnt=3; sym_done after
//    16 carries; underrun pulses; FSM returns to IDLE.
//  3 Stream symbols 0,1,3 with sym_valid held -> each accepted in its prefetch window;
//    one LOAD cycle between symbols; div_cnt 7,5,1; no underrun until the end.
//  4 Write tone[1]=2 during the symbol 1 RUN -> current div_cnt stays 5; the next
//    symbol 1 loads 2.
//  5 Drop enable mid-symbol -> symbol completes, sym_ready stays 0, no underrun;
//    pulse rst mid-RUN -> IDLE immediately.
//  6 With FSK_IDLE_TONE_EN: starve the input -> underrun, then LOAD with div_cnt=tone[0];
//    the carrier keeps running.

Source files
------------

// File: rtl/modulation_pkg.sv
// rtl/modulation_pkg.sv - FSM encoding, default widths and helpers for the FSK divider scheduler
package modulation_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } sched_state_e;

   localparam int DEF_CNT_W           = 3;
   localparam int DEF_SYM_W           = 2;
   localparam int DEF_CARRIES_PER_SYM = 16;

   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fsk_carry_counter.sv
// rtl/fsk_carry_counter.sv - counts divider carries within a symbol, flags the terminal count
module fsk_carry_counter
   import modulation_pkg::*;
#(
   parameter int TERMINAL = DEF_CARRIES_PER_SYM
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic carry_i,
   output logic term_o
);

   localparam int CW = cnt_width(TERMINAL);

   logic [CW-1:0] count_q, count_d;

   assign term_o = (count_q == CW'(TERMINAL - 1));

   // The terminal carry always leaves RUN, so the count never needs to wrap.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (carry_i && !term_o) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/fsk_div_scheduler.sv
// rtl/fsk_div_scheduler.sv - symbol-to-tone sequencer driving freqdivider cnt/init/sel
// Optional FSK_IDLE_TONE_EN: on underrun with enable high, load symbol 0 instead of idling.
module fsk_div_scheduler
   import modulation_pkg::*;
#(
   parameter int CNT_W           = DEF_CNT_W,
   parameter int SYM_W           = DEF_SYM_W,
   parameter int CARRIES_PER_SYM = DEF_CARRIES_PER_SYM
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             cfg_we,
   input  logic [SYM_W-1:0] cfg_addr,
   input  logic [CNT_W-1:0] cfg_data,
   input  logic             sym_valid,
   input  logic [SYM_W-1:0] sym_data,
   output logic             sym_ready,
   input  logic             div_carry,
   output logic [CNT_W-1:0] div_cnt,
   output logic             div_init,
   output logic             div_sel,
   output logic             busy,
   output logic             sym_done,
   output logic             underrun
);

   localparam int DEPTH = 2 ** SYM_W;

   sched_state_e     state_q, state_d;
   logic [CNT_W-1:0] tone_q [DEPTH];
   logic [SYM_W-1:0] sym_q, sym_d;
   logic [SYM_W-1:0] pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
   logic [CNT_W-1:0] tone_sel;
   logic             cnt_clr, cnt_inc, term;

   assign tone_sel = tone_q[sym_q];

   fsk_carry_counter #(
      .TERMINAL (CARRIES_PER_SYM)
   ) u_carry_counter (
      .clk     (clk),
      .rst_n   (rst),
      .clr_i   (cnt_clr),
      .carry_i (cnt_inc),
      .term_o  (term)
   );

   // Table writes land at the clock edge, so a LOAD in the same cycle sees the old entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            tone_q[i] <= '0;
         end
      end else if (cfg_we) begin
         tone_q[cfg_addr] <= cfg_data;
      end
   end

   always_comb begin
      state_d    = state_q;
      sym_d      = sym_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      div_cnt_d  = div_cnt_q;
      sym_ready  = 1'b0;
      div_init   = 1'b0;
      sym_done   = 1'b0;
      underrun   = 1'b0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            sym_ready = enable;
            if (sym_valid && enable) begin
               sym_d   = sym_data;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            div_init  = 1'b1;
            div_cnt_d = tone_sel;
            cnt_clr   = 1'b1;
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            sym_ready = enable && !pend_vld_q && term;
            cnt_inc   = div_carry;
            if (sym_valid && sym_ready) begin
               pend_d     = sym_data;
               pend_vld_d = 1'b1;
            end
            if (div_carry && term) begin
               sym_done = 1'b1;
               // A symbol accepted on the terminal carry itself goes straight to LOAD.
               if (pend_vld_q) begin
                  sym_d      = pend_q;
                  pend_vld_d = 1'b0;
                  state_d    = ST_LOAD;
               end else if (sym_valid && sym_ready) begin
                  sym_d      = sym_data;
                  pend_vld_d = 1'b0;
                  state_d    = ST_LOAD;
               end else begin
                  underrun = enable;
`ifdef FSK_IDLE_TONE_EN
                  if (enable) begin
                     sym_d   = '0;
                     state_d = ST_LOAD;
                  end else begin
                     state_d = ST_IDLE;
                  end
`else
                  state_d = ST_IDLE;
`endif
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         sym_q      <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         div_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         sym_q      <= sym_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         div_cnt_q  <= div_cnt_d;
      end
   end

   // The divider samples cnt while init is high, so LOAD presents the table entry directly.
   assign div_cnt = (state_q == ST_LOAD) ? tone_sel : div_cnt_q;
   assign div_sel = 1'b0;
   assign busy    = (state_q != ST_IDLE);

endmodule
